// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard control (load-use, branch flush, DIV sequencing)
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int DIV_LAT      = 33,
    parameter int CNT_W        = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_dst,
    input  logic        ex_is_load,
    input  logic        ex_is_div,
    input  logic        branch_taken,
    input  logic        div_done,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        flush_if,
    output logic        flush_id,
    output logic        div_start,
    output logic        busy,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_FLUSH   = 2'd1,
        S_DIVWAIT = 2'd2
    } state_t;

    localparam logic             c_flush_multi = (FLUSH_CYCLES > 1);
    localparam logic [CNT_W-1:0] c_flush_init  = CNT_W'(FLUSH_CYCLES - 2);
    localparam logic [CNT_W-1:0] c_div_init    = CNT_W'(DIV_LAT - 2);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_stall_cnt;
    logic [31:0]       r_flush_cnt;
    logic              w_load_use;
    logic              w_cnt_zero;

    assign w_load_use = ex_is_load && (ex_dst != 5'd0) &&
                        ((id_use_rs1 && (id_rs1 == ex_dst)) ||
                         (id_use_rs2 && (id_rs2 == ex_dst)));
    assign w_cnt_zero = (r_cnt == '0);

    // Control lines react in the same cycle; everything is forced low in reset.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        flush_if  = 1'b0;
        flush_id  = 1'b0;
        div_start = 1'b0;
        busy      = 1'b0;
        if (rst_n) begin
            busy = (r_state != S_RUN);
            case (r_state)
                S_RUN: begin
                    if (branch_taken) begin
                        flush_if = 1'b1;
                        flush_id = 1'b1;
                    end else if (ex_is_div) begin
                        div_start = 1'b1;
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                    end else if (w_load_use) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_id = 1'b1;
                    end
                end
                S_FLUSH: begin
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                end
                S_DIVWAIT: begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                end
                default: begin
                    busy = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_cnt       <= '0;
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (stall_if) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            case (r_state)
                S_RUN: begin
                    if (branch_taken) begin
                        r_flush_cnt <= r_flush_cnt + 32'd1;
                        if (c_flush_multi) begin
                            r_state <= S_FLUSH;
                            r_cnt   <= c_flush_init;
                        end
                    end else if (ex_is_div) begin
                        r_state <= S_DIVWAIT;
                        r_cnt   <= c_div_init;
                    end
                end
                S_FLUSH: begin
                    if (w_cnt_zero) begin
                        r_state <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DIVWAIT: begin
                    // Early result or latency budget exhausted both release the stall.
                    if (div_done || w_cnt_zero) begin
                        r_state <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed self-checking bench for hazard_ctrl
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_dst;
    logic        ex_is_load;
    logic        ex_is_div;
    logic        branch_taken;
    logic        div_done;
    logic        stall_if;
    logic        stall_id;
    logic        stall_ex;
    logic        flush_if;
    logic        flush_id;
    logic        div_start;
    logic        busy;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int checks = 0;
    int errors = 0;

    // {stall_if, stall_id, stall_ex, flush_if, flush_id, div_start, busy}
    logic [6:0] outs;
    assign outs = {stall_if, stall_id, stall_ex, flush_if, flush_id, div_start, busy};

    localparam logic [6:0] c_idle = 7'b0000000;
    localparam logic [6:0] c_lu   = 7'b1100100;
    localparam logic [6:0] c_br   = 7'b0001100;
    localparam logic [6:0] c_fl   = 7'b0001101;
    localparam logic [6:0] c_ds   = 7'b1110010;
    localparam logic [6:0] c_dw   = 7'b1110001;

    hazard_ctrl #(
        .FLUSH_CYCLES (2),
        .DIV_LAT      (33),
        .CNT_W        (6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_dst       (ex_dst),
        .ex_is_load   (ex_is_load),
        .ex_is_div    (ex_is_div),
        .branch_taken (branch_taken),
        .div_done     (div_done),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .stall_ex     (stall_ex),
        .flush_if     (flush_if),
        .flush_id     (flush_id),
        .div_start    (div_start),
        .busy         (busy),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_rs1       = 5'd0;
        id_rs2       = 5'd0;
        id_use_rs1   = 1'b0;
        id_use_rs2   = 1'b0;
        ex_dst       = 5'd0;
        ex_is_load   = 1'b0;
        ex_is_div    = 1'b0;
        branch_taken = 1'b0;
        div_done     = 1'b0;
    endtask

    // Leaves the bench at a negedge with rst_n released and counters cleared.
    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n        = 1'b0;
        branch_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (outs !== c_idle || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
                errors++;
                $display("FAIL reset_hold: outs=%b sc=%0d fc=%0d required outs=%b sc=0 fc=0",
                         outs, stall_cnt, flush_cnt, c_idle);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs !== c_br) begin
            errors++;
            $display("FAIL reset_release_branch: outs=%b required %b", outs, c_br);
        end
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        checks++;
        if (outs !== c_fl || flush_cnt !== 32'd1) begin
            errors++;
            $display("FAIL reset_first_flush: outs=%b fc=%0d required outs=%b fc=1",
                     outs, flush_cnt, c_fl);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_is_load = 1'b1; ex_dst = 5'd5; id_use_rs2 = 1'b1; id_rs2 = 5'd5;
        #1;
        checks++;
        if (outs !== c_lu) begin
            errors++;
            $display("FAIL load_use_rs2: outs=%b required %b", outs, c_lu);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (outs !== c_idle || stall_cnt !== 32'd1) begin
            errors++;
            $display("FAIL load_use_bubble: outs=%b sc=%0d required outs=%b sc=1",
                     outs, stall_cnt, c_idle);
        end
        ex_is_load = 1'b1; ex_dst = 5'd0; id_use_rs2 = 1'b1; id_rs2 = 5'd0;
        #1;
        checks++;
        if (outs !== c_idle) begin
            errors++;
            $display("FAIL load_use_x0: outs=%b required %b", outs, c_idle);
        end
        @(negedge clk);
        idle_inputs();
        ex_is_load = 1'b1; ex_dst = 5'd7; id_use_rs1 = 1'b1; id_rs1 = 5'd7;
        #1;
        checks++;
        if (outs !== c_lu || stall_cnt !== 32'd1) begin
            errors++;
            $display("FAIL load_use_rs1: outs=%b sc=%0d required outs=%b sc=1",
                     outs, stall_cnt, c_lu);
        end
        @(negedge clk);
        id_use_rs1 = 1'b0;
        #1;
        checks++;
        if (outs !== c_idle || stall_cnt !== 32'd2) begin
            errors++;
            $display("FAIL load_use_unused_rs1: outs=%b sc=%0d required outs=%b sc=2",
                     outs, stall_cnt, c_idle);
        end
        ex_is_load = 1'b0; id_use_rs2 = 1'b1; id_rs2 = 5'd7;
        #1;
        checks++;
        if (outs !== c_idle) begin
            errors++;
            $display("FAIL load_use_not_load: outs=%b required %b", outs, c_idle);
        end
        idle_inputs();
    endtask

    task automatic test_branch_flush();
        do_reset();
        branch_taken = 1'b1;
        #1;
        checks++;
        if (outs !== c_br) begin
            errors++;
            $display("FAIL branch_first: outs=%b required %b", outs, c_br);
        end
        @(negedge clk);
        ex_is_load = 1'b1; ex_dst = 5'd3; id_use_rs1 = 1'b1; id_rs1 = 5'd3;
        #1;
        checks++;
        if (outs !== c_fl) begin
            errors++;
            $display("FAIL branch_in_flush: outs=%b required %b", outs, c_fl);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (outs !== c_idle || flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL branch_end: outs=%b fc=%0d sc=%0d required outs=%b fc=1 sc=0",
                     outs, flush_cnt, stall_cnt, c_idle);
        end
    endtask

    task automatic test_div_early();
        int bad;
        do_reset();
        ex_is_div = 1'b1;
        #1;
        checks++;
        if (outs !== c_ds) begin
            errors++;
            $display("FAIL div_start: outs=%b required %b", outs, c_ds);
        end
        bad = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            ex_is_div    = 1'b0;
            branch_taken = (i == 4);
            div_done     = (i == 10);
            #1;
            if (outs !== c_dw) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL div_wait: %0d cycles differed from %b", bad, c_dw);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (outs !== c_idle || stall_cnt !== 32'd11 || flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL div_early_done: outs=%b sc=%0d fc=%0d required outs=%b sc=11 fc=0",
                     outs, stall_cnt, flush_cnt, c_idle);
        end
        div_done = 1'b1;
        #1;
        checks++;
        if (outs !== c_idle) begin
            errors++;
            $display("FAIL div_done_in_run: outs=%b required %b", outs, c_idle);
        end
        idle_inputs();
    endtask

    task automatic test_div_timeout();
        int n_stall;
        int n_busy;
        do_reset();
        ex_is_div = 1'b1;
        n_stall = 0;
        n_busy  = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (stall_if && stall_id && stall_ex) n_stall++;
            if (busy) n_busy++;
            @(negedge clk);
            ex_is_div = 1'b0;
        end
        checks++;
        if (n_stall != 33 || n_busy != 32) begin
            errors++;
            $display("FAIL div_timeout: stall cycles=%0d busy cycles=%0d required 33 and 32",
                     n_stall, n_busy);
        end
        checks++;
        if (stall_cnt !== 32'd33) begin
            errors++;
            $display("FAIL div_timeout_cnt: sc=%0d required 33", stall_cnt);
        end
    endtask

    task automatic test_priority_and_abort();
        do_reset();
        branch_taken = 1'b1; ex_is_div = 1'b1;
        ex_is_load = 1'b1; ex_dst = 5'd9; id_use_rs2 = 1'b1; id_rs2 = 5'd9;
        #1;
        checks++;
        if (outs !== c_br) begin
            errors++;
            $display("FAIL priority: outs=%b required %b", outs, c_br);
        end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== c_fl || flush_cnt !== 32'd1) begin
            errors++;
            $display("FAIL priority_flush_state: outs=%b fc=%0d required outs=%b fc=1",
                     outs, flush_cnt, c_fl);
        end
        do_reset();
        ex_is_div = 1'b1;
        repeat (4) begin
            @(negedge clk);
            ex_is_div = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== c_idle) begin
            errors++;
            $display("FAIL abort_in_reset: outs=%b required %b", outs, c_idle);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs !== c_idle || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL abort_after: outs=%b sc=%0d fc=%0d required outs=%b sc=0 fc=0",
                     outs, stall_cnt, flush_cnt, c_idle);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_flush();
        test_div_early();
        test_div_timeout();
        test_priority_and_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
